alu_fifo_sequencer: RTL and testbench



---
 rtl/alu_fifo_sequencer_pkg.sv | 31 +++
 rtl/alu_fifo_sequencer_if.sv | 41 ++++
 rtl/alu_fifo_sequencer_watchdog.sv | 49 ++++
 rtl/alu_fifo_sequencer.sv | 146 ++++++++++++++
 tb/tb_alu_fifo_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_fifo_sequencer_pkg.sv
// ============================================================================
// Module      : alu_seq_pkg
// Description : Shared state encoding, default widths and the watchdog
//               counter-width helper for the ALU/FIFO sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_seq_pkg;

  localparam int unsigned NB_DATA_DEF        = 8;
  localparam int unsigned NB_OP_DEF          = 6;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 1000000;

  typedef logic [2:0] state_t;

  localparam state_t WAIT_A  = 3'd0;
  localparam state_t WAIT_B  = 3'd1;
  localparam state_t WAIT_OP = 3'd2;
  localparam state_t EXEC    = 3'd3;
  localparam state_t PUSH    = 3'd4;
  localparam state_t GAP     = 3'd5;

  // Counter only has to reach n-1, so clog2(n) bits suffice.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_fifo_sequencer_if.sv
// ============================================================================
// Module      : alu_fifo_sequencer_if
// Description : Bundle of the RX FIFO, TX FIFO, ALU and status signals seen
//               by the sequencer (master) and its environment (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_fifo_sequencer_if #(
  parameter int unsigned NB_DATA = alu_seq_pkg::NB_DATA_DEF,
  parameter int unsigned NB_OP   = alu_seq_pkg::NB_OP_DEF
);

  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_empty;
  logic               o_rx_read;
  logic [NB_DATA-1:0] o_tx_data;
  logic               o_tx_write;
  logic               i_tx_full;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic               o_busy;
  logic               o_timeout;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full, i_alu_result,
    output o_rx_read, o_tx_data, o_tx_write, o_alu_a, o_alu_b, o_alu_op,
           o_busy, o_timeout
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full, i_alu_result,
    input  o_rx_read, o_tx_data, o_tx_write, o_alu_a, o_alu_b, o_alu_op,
           o_busy, o_timeout
  );

endinterface

`default_nettype wire

// File: rtl/alu_fifo_sequencer_watchdog.sv
// ============================================================================
// Module      : alu_seq_watchdog
// Description : Operand-wait watchdog; flags expiry when the RX FIFO has been
//               empty for TIMEOUT_CYCLES-1 cycles of a running wait.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_watchdog
  import alu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  wire logic i_clk,
  input  wire logic i_rst,
  input  wire logic i_run,
  input  wire logic i_clear,
  input  wire logic i_rx_empty,
  output logic      o_expire
);

  localparam int unsigned    c_cnt_w = cnt_width(TIMEOUT_CYCLES);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

  logic [c_cnt_w-1:0] cnt_q;
  logic [c_cnt_w-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_run && (cnt_q != c_last)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_run & i_rx_empty & (cnt_q == c_last);

endmodule

`default_nettype wire

// File: rtl/alu_fifo_sequencer.sv
// ============================================================================
// Module      : alu_fifo_sequencer
// Description : Pops A, B and opcode from the RX FIFO, runs them through the
//               ALU and pushes the result to the TX FIFO as a single strobe.
//               Optional operand-wait watchdog: define ALU_SEQ_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_fifo_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned NB_DATA        = NB_DATA_DEF,
  parameter int unsigned NB_OP          = NB_OP_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  wire logic             i_clk,
  input  wire logic             i_rst,
  alu_fifo_sequencer_if.master  bus
);

  state_t             state_q, state_d;
  logic [NB_DATA-1:0] a_q, a_d;
  logic [NB_DATA-1:0] b_q, b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic [NB_DATA-1:0] res_q, res_d;
  logic               w_pop;
  logic               w_push;
  logic               w_expire;
  logic               w_waiting;

  assign w_waiting = (state_q == WAIT_B) || (state_q == WAIT_OP);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    w_pop   = 1'b0;
    w_push  = 1'b0;
    case (state_q)
      WAIT_A: begin
        if (!bus.i_rx_empty) begin
          w_pop   = 1'b1;
          a_d     = bus.i_rx_data;
          state_d = WAIT_B;
        end
      end
      WAIT_B: begin
        if (!bus.i_rx_empty) begin
          w_pop   = 1'b1;
          b_d     = bus.i_rx_data;
          state_d = WAIT_OP;
        end else if (w_expire) begin
          a_d     = '0;
          b_d     = '0;
          state_d = WAIT_A;
        end
      end
      WAIT_OP: begin
        if (!bus.i_rx_empty) begin
          w_pop   = 1'b1;
          op_d    = bus.i_rx_data[NB_OP-1:0];
          state_d = EXEC;
        end else if (w_expire) begin
          a_d     = '0;
          b_d     = '0;
          state_d = WAIT_A;
        end
      end
      EXEC: begin
        res_d   = bus.i_alu_result;
        state_d = PUSH;
      end
      PUSH: begin
        if (!bus.i_tx_full) begin
          w_push  = 1'b1;
          state_d = GAP;
        end
      end
      GAP:     state_d = WAIT_A;
      default: state_d = WAIT_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

`ifdef ALU_SEQ_TIMEOUT_EN
  logic timeout_q;

  alu_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_run      (w_waiting),
    .i_clear    (w_pop | ~w_waiting),
    .i_rx_empty (bus.i_rx_empty),
    .o_expire   (w_expire)
  );

  // Pulse lands in the first WAIT_A cycle after the abort.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= w_expire;
    end
  end

  assign bus.o_timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, w_waiting};
  assign w_expire           = 1'b0;
  assign bus.o_timeout      = 1'b0;
`endif

  // Strobes are forced low for the whole reset cycle, not just after the edge.
  assign bus.o_rx_read  = w_pop & ~i_rst;
  assign bus.o_tx_write = w_push & ~i_rst;
  assign bus.o_tx_data  = res_q;
  assign bus.o_alu_a    = a_q;
  assign bus.o_alu_b    = b_q;
  assign bus.o_alu_op   = op_q;
  assign bus.o_busy     = (state_q != WAIT_A);

endmodule

`default_nettype wire

// File: tb/tb_alu_fifo_sequencer.sv
// ============================================================================
// Module      : tb_alu_fifo_sequencer
// Description : Directed self-checking bench: FIFO models, ADD/SUB ALU model,
//               hand-computed expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_fifo_sequencer;

  logic clk;
  logic rst;
  logic tx_full;

  int n_tests;
  int n_fail;

  logic [7:0] rx_mem [0:63];
  int         rx_wr;
  int         rx_rd;

  int         cyc;
  int         rx_reads;
  int         tx_cnt;
  logic [7:0] tx_log [0:31];
  int         wr_cyc [0:31];
  int         last_pop_cyc;
  int         consec_wr;
  logic       prev_wr;

  alu_fifo_sequencer_if #(.NB_DATA(8), .NB_OP(6)) bus ();

  alu_fifo_sequencer #(
    .NB_DATA        (8),
    .NB_OP          (6),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.i_rx_empty   = (rx_rd == rx_wr);
  assign bus.i_rx_data    = rx_mem[rx_rd % 64];
  assign bus.i_tx_full    = tx_full;
  assign bus.i_alu_result = (bus.o_alu_op == 6'h20) ? bus.o_alu_a + bus.o_alu_b :
                            (bus.o_alu_op == 6'h22) ? bus.o_alu_a - bus.o_alu_b : 8'h00;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    prev_wr <= bus.o_tx_write;
    if (bus.o_rx_read) begin
      rx_rd        <= rx_rd + 1;
      rx_reads     <= rx_reads + 1;
      last_pop_cyc <= cyc;
    end
    if (bus.o_tx_write) begin
      tx_log[tx_cnt % 32] <= bus.o_tx_data;
      wr_cyc[tx_cnt % 32] <= cyc;
      tx_cnt              <= tx_cnt + 1;
      if (prev_wr) consec_wr <= consec_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] v);
    rx_mem[rx_wr % 64] = v;
    rx_wr++;
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && tx_cnt < target; i++) tick(1);
    check(tag, tx_cnt, target);
  endtask

  int base;
  int busy_low;
  int reads0;

  initial begin
    n_tests = 0; n_fail = 0;
    rx_wr = 0; rx_rd = 0; cyc = 0; rx_reads = 0; tx_cnt = 0;
    last_pop_cyc = 0; consec_wr = 0; prev_wr = 1'b0;
    tx_full = 1'b0;
    rst = 1'b1;
    tick(2);

    // Reset state
    check("rst_busy",    bus.o_busy,     0);
    check("rst_rx_read", bus.o_rx_read,  0);
    check("rst_tx_wr",   bus.o_tx_write, 0);
    check("rst_regs",    {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op, bus.o_tx_data}, 0);
    check("rst_timeout", bus.o_timeout,  0);
    rst = 1'b0;
    tick(2);

    // Basic ADD: 5 + 3
    base = tx_cnt;
    push(8'h05); push(8'h03); push(8'h20);
    wait_writes("add_wait", base + 1, 20);
    check("add_reads",   rx_reads, 3);
    check("add_result",  tx_log[base], 8'h08);
    check("add_latency", wr_cyc[base] - last_pop_cyc, 2);
    check("add_alu_ops", {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op}, 24'h050320);
    tick(3);
    check("add_single",  tx_cnt, base + 1);

    // Back-to-back ADD then SUB
    base = tx_cnt;
    push(8'h05); push(8'h03); push(8'h20); push(8'h0A); push(8'h04); push(8'h22);
    wait_writes("b2b_wait", base + 2, 40);
    check("b2b_res0",   tx_log[base],     8'h08);
    check("b2b_res1",   tx_log[base + 1], 8'h06);
    check("b2b_period", wr_cyc[base + 1] - wr_cyc[base], 6);
    check("b2b_consec", consec_wr, 0);
    tick(3);

    // TX backpressure with a second op queued behind the first
    base   = tx_cnt;
    reads0 = rx_reads;
    tx_full = 1'b1;
    push(8'h05); push(8'h03); push(8'h20); push(8'h0A); push(8'h04); push(8'h22);
    tick(15);
    check("bp_no_write", tx_cnt, base);
    check("bp_no_pop",   rx_reads - reads0, 3);
    check("bp_held",     bus.o_tx_data, 8'h08);
    check("bp_busy",     bus.o_busy, 1);
    tx_full = 1'b0;
    wait_writes("bp_wait", base + 2, 40);
    check("bp_res0",   tx_log[base],     8'h08);
    check("bp_res1",   tx_log[base + 1], 8'h06);
    check("bp_consec", consec_wr, 0);
    tick(3);

    // Starved RX between A and B
    base = tx_cnt;
    busy_low = 0;
    push(8'h05);
    tick(1);
    for (int i = 0; i < 50; i++) begin
      if (!bus.o_busy) busy_low++;
      tick(1);
    end
    check("starve_busy",  busy_low, 0);
    check("starve_nowr",  tx_cnt, base);
    push(8'h03); push(8'h20);
    wait_writes("starve_wait", base + 1, 20);
    check("starve_res",   tx_log[base], 8'h08);
    tick(3);

    // Reset in the middle of an operation
    base = tx_cnt;
    push(8'h05); push(8'h03);
    tick(4);
    check("mid_a_loaded", bus.o_alu_b, 8'h03);
    rst = 1'b1;
    tick(1);
    check("mid_rst_regs", {bus.o_alu_a, bus.o_alu_b, 2'b00, bus.o_alu_op, bus.o_tx_data}, 0);
    check("mid_rst_ctl",  {bus.o_busy, bus.o_rx_read, bus.o_tx_write, bus.o_timeout}, 0);
    rst = 1'b0;
    tick(5);
    check("mid_no_write", tx_cnt, base);
    push(8'h07); push(8'h01); push(8'h20);
    wait_writes("mid_wait", base + 1, 20);
    check("mid_res", tx_log[base], 8'h08);
    tick(3);

`ifdef ALU_SEQ_TIMEOUT_EN
    // Watchdog abort after a lone operand A
    begin
      int seen;
      seen = -1;
      base = tx_cnt;
      push(8'h05);
      for (int i = 1; i <= 40 && seen < 0; i++) begin
        tick(1);
        if (bus.o_timeout) seen = i - 1;
      end
      check("to_cycle", seen, 16);
      check("to_idle",  bus.o_busy, 0);
      check("to_a_clr", bus.o_alu_a, 0);
      tick(1);
      check("to_pulse", bus.o_timeout, 0);
      push(8'h02); push(8'h02); push(8'h20);
      wait_writes("to_wait", base + 1, 20);
      check("to_res", tx_log[base], 8'h04);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
